uart_rx_fsm_ctrl: RTL and testbench

Frame sequencer for the UART receiver. Detects the start edge on RX_IN and runs the oversampling edge/bit counters. Issues one-cycle enables to the sampler, deserializer, start/parity/stop checkers. Collects their error flags and raises data_valid or frame_err once per frame.

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_edge_bit_cnt.sv | 66 ++++++
 rtl/uart_rx_fsm_ctrl.sv | 131 +++++++++++++
 tb/tb_uart_rx_fsm_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive path
package uart_rx_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        DONE   = 3'd5
    } rx_state_t;

    // Smallest oversample ratio the sampler majority window fits into
    localparam int MIN_PRESCALE = 8;
    localparam int DATA_W_DEF   = 8;
    localparam int PRESC_W_DEF  = 6;

    // States that occupy oversample ticks of a serial bit on the line
    function automatic logic in_bit_time(input rx_state_t s);
        return (s == START) || (s == DATA) || (s == PARITY) || (s == STOP);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversample edge counter, bit counter and ratio latch
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic                    CLK_STOP_CHECK,
    input  logic                    RST_STOP_CHECK,
    input  logic [PRESC_W-1:0]      prescale,
    input  logic                    ratio_load,
    input  logic                    cnt_en,
    input  logic                    cnt_clr,
    input  logic                    bit_adv,
    input  logic                    bit_clr,
    output logic [PRESC_W-1:0]      edge_cnt,
    output logic [$clog2(DATA_W):0] bit_cnt,
    output logic                    edge_wrap
);

    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam logic [PRESC_W-1:0] MIN_RATIO = PRESC_W'(MIN_PRESCALE);
    localparam logic [PRESC_W-1:0] EDGE_ONE  = PRESC_W'(1);
    localparam logic [BIT_W-1:0]   BIT_ONE   = BIT_W'(1);

    logic [PRESC_W-1:0] ratio;
    logic [PRESC_W-1:0] ratio_clamped;

    // Ratios below the sampler window are raised to the minimum
    assign ratio_clamped = (prescale < MIN_RATIO) ? MIN_RATIO : prescale;

    // Last tick of the current bit
    assign edge_wrap = (edge_cnt == (ratio - EDGE_ONE));

    // Ratio is frozen for a whole frame; only a frame start may reload it
    always_ff @(posedge CLK_STOP_CHECK or negedge RST_STOP_CHECK) begin
        if (!RST_STOP_CHECK) begin
            ratio <= MIN_RATIO;
        end else if (ratio_load) begin
            ratio <= ratio_clamped;
        end
    end

    // Oversample tick within the bit, wrapping at the latched ratio
    always_ff @(posedge CLK_STOP_CHECK or negedge RST_STOP_CHECK) begin
        if (!RST_STOP_CHECK) begin
            edge_cnt <= '0;
        end else if (cnt_clr) begin
            edge_cnt <= '0;
        end else if (cnt_en) begin
            edge_cnt <= edge_wrap ? '0 : (edge_cnt + EDGE_ONE);
        end
    end

    // Data bit index; holds through parity/stop so it reads as the last bit
    always_ff @(posedge CLK_STOP_CHECK or negedge RST_STOP_CHECK) begin
        if (!RST_STOP_CHECK) begin
            bit_cnt <= '0;
        end else if (cnt_clr || bit_clr) begin
            bit_cnt <= '0;
        end else if (bit_adv) begin
            bit_cnt <= bit_cnt + BIT_ONE;
        end
    end

endmodule

// File: rtl/uart_rx_fsm_ctrl.sv
// rtl/uart_rx_fsm_ctrl.sv - UART receive frame sequencer with checker strobes and frame status
module uart_rx_fsm_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PRESC_W = PRESC_W_DEF
) (
    input  logic                    CLK_STOP_CHECK,
    input  logic                    RST_STOP_CHECK,
    input  logic                    RX_IN,
    input  logic                    PAR_EN,
    input  logic [PRESC_W-1:0]      PRESCALE,
    input  logic                    strt_glitch,
    input  logic                    par_err,
    input  logic                    stp_err,
    output logic                    dat_samp_en,
    output logic [PRESC_W-1:0]      edge_cnt,
    output logic [$clog2(DATA_W):0] bit_cnt,
    output logic                    deser_en,
    output logic                    strt_chk_en,
    output logic                    par_chk_en,
    output logic                    stp_chk_en,
    output logic                    data_valid,
    output logic                    frame_err
);

    localparam int BIT_W = $clog2(DATA_W) + 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

    rx_state_t state;
    rx_state_t state_nxt;
    logic      par_flag;

    logic      edge_wrap;
    logic      edge_zero;
    logic      first_bit;
    logic      last_bit;

    logic      ratio_load;
    logic      cnt_en;
    logic      cnt_clr;
    logic      bit_adv;
    logic      bit_clr;

    assign edge_zero = (edge_cnt == '0);
    assign first_bit = (bit_cnt == '0);
    assign last_bit  = (bit_cnt == LAST_BIT);

    uart_rx_edge_bit_cnt #(
        .DATA_W  (DATA_W),
        .PRESC_W (PRESC_W)
    ) u_edge_bit_cnt (
        .CLK_STOP_CHECK (CLK_STOP_CHECK),
        .RST_STOP_CHECK (RST_STOP_CHECK),
        .prescale       (PRESCALE),
        .ratio_load     (ratio_load),
        .cnt_en         (cnt_en),
        .cnt_clr        (cnt_clr),
        .bit_adv        (bit_adv),
        .bit_clr        (bit_clr),
        .edge_cnt       (edge_cnt),
        .bit_cnt        (bit_cnt),
        .edge_wrap      (edge_wrap)
    );

    // Next-state selection from registered state, counters, line and checker results
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!RX_IN) state_nxt = START;
            end
            START: begin
                if (edge_wrap) state_nxt = DATA;
            end
            DATA: begin
                // A start glitch reported right after the start check abandons the frame silently
                if (edge_zero && first_bit && strt_glitch) begin
                    state_nxt = IDLE;
                end else if (edge_wrap && last_bit) begin
                    state_nxt = PAR_EN ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (edge_wrap) state_nxt = STOP;
            end
            STOP: begin
                if (edge_wrap) state_nxt = DONE;
            end
            DONE: begin
                // A low line here is already tick 0 of the next start bit
                state_nxt = RX_IN ? IDLE : START;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State register plus the parity result held until the frame verdict
    always_ff @(posedge CLK_STOP_CHECK or negedge RST_STOP_CHECK) begin
        if (!RST_STOP_CHECK) begin
            state    <= IDLE;
            par_flag <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == DONE) begin
                par_flag <= 1'b0;
            end else if ((state == STOP) && edge_zero && PAR_EN) begin
                par_flag <= par_err;
            end
        end
    end

    // Counter control: reload the ratio on every frame start, count while on a bit
    assign ratio_load = ((state == IDLE) || (state == DONE)) && (state_nxt == START);
    assign cnt_clr    = (state_nxt == IDLE);
    assign cnt_en     = (state != IDLE);
    assign bit_clr    = (state == START) && edge_wrap;
    assign bit_adv    = (state == DATA) && edge_wrap && !last_bit;

    // Output decode from registered state and counters
    assign dat_samp_en = in_bit_time(state);
    assign strt_chk_en = (state == START)  && edge_wrap;
    assign deser_en    = (state == DATA)   && edge_wrap;
    assign par_chk_en  = (state == PARITY) && edge_wrap;
    assign stp_chk_en  = (state == STOP)   && edge_wrap;
    assign data_valid  = (state == DONE)   && !stp_err && !par_flag;
    assign frame_err   = (state == DONE)   && (stp_err || par_flag);

endmodule

// File: tb/tb_uart_rx_fsm_ctrl.sv
// tb/tb_uart_rx_fsm_ctrl.sv - self-checking bench for uart_rx_fsm_ctrl
module tb_uart_rx_fsm_ctrl;

    localparam int DW = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic       par_en;
    logic [5:0] prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       deser_en;
    logic       strt_chk_en;
    logic       par_chk_en;
    logic       stp_chk_en;
    logic       data_valid;
    logic       frame_err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int s, s1, s2;

    // Frame model: position of the current cycle inside the frame, in oversample ticks
    logic m_active = 1'b0;
    int   m_off    = 0;
    int   m_p      = 8;
    logic m_pe     = 1'b0;
    logic m_flag   = 1'b0;
    logic m_b2b    = 1'b0;

    int   deser_q[$];
    int   strt_q[$];
    int   par_q[$];
    int   stp_q[$];
    int   dv_q[$];
    int   fe_q[$];
    int   edge_after_dv_q[$];
    logic dv_prev = 1'b0;

    int   ptab[6] = '{0, 4, 7, 8, 16, 32};

    uart_rx_fsm_ctrl dut (
        .CLK_STOP_CHECK (clk),
        .RST_STOP_CHECK (rst_n),
        .RX_IN          (rx_in),
        .PAR_EN         (par_en),
        .PRESCALE       (prescale),
        .strt_glitch    (strt_glitch),
        .par_err        (par_err),
        .stp_err        (stp_err),
        .dat_samp_en    (dat_samp_en),
        .edge_cnt       (edge_cnt),
        .bit_cnt        (bit_cnt),
        .deser_en       (deser_en),
        .strt_chk_en    (strt_chk_en),
        .par_chk_en     (par_chk_en),
        .stp_chk_en     (stp_chk_en),
        .data_valid     (data_valid),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_evt(input string name, input int n, input int n_exp,
                             input int t_rel, input int t_exp);
        check({name, "_count"}, n, n_exp);
        if (n_exp > 0 && n > 0) check({name, "_time"}, t_rel, t_exp);
    endtask

    function automatic int eff_p(input logic [5:0] v);
        return (int'(v) < 8) ? 8 : int'(v);
    endfunction

    // Per-cycle comparison against the frame model, then advance the model
    always @(negedge clk) begin
        int   len, seg, ed;
        int   e_samp, e_edge, e_bit, e_strt, e_deser, e_par, e_stp, e_dv, e_fe;
        if (!rst_n) begin
            m_active <= 1'b0;
            m_off    <= 0;
            m_p      <= 8;
            m_flag   <= 1'b0;
            m_b2b    <= 1'b0;
            dv_prev  <= 1'b0;
        end else begin
            len = (DW + 2 + int'(m_pe)) * m_p;
            e_samp = 0; e_edge = 0; e_bit = 0; e_strt = 0; e_deser = 0;
            e_par = 0; e_stp = 0; e_dv = 0; e_fe = 0;
            if (m_active) begin
                if (m_off < len) begin
                    seg     = m_off / m_p;
                    ed      = m_off % m_p;
                    e_samp  = 1;
                    e_edge  = ed;
                    e_strt  = int'(seg == 0 && ed == m_p - 1);
                    e_deser = int'(seg >= 1 && seg <= DW && ed == m_p - 1);
                    e_par   = int'(m_pe && seg == DW + 1 && ed == m_p - 1);
                    e_stp   = int'(seg == DW + 1 + int'(m_pe) && ed == m_p - 1);
                    if (seg == 0)       e_bit = m_b2b ? DW - 1 : 0;
                    else if (seg <= DW) e_bit = seg - 1;
                    else                e_bit = DW - 1;
                end else begin
                    e_bit = DW - 1;
                    e_dv  = int'(!stp_err && !m_flag);
                    e_fe  = 1 - e_dv;
                end
            end
            check("dat_samp_en", int'(dat_samp_en), e_samp);
            check("edge_cnt",    int'(edge_cnt),    e_edge);
            check("bit_cnt",     int'(bit_cnt),     e_bit);
            check("strt_chk_en", int'(strt_chk_en), e_strt);
            check("deser_en",    int'(deser_en),    e_deser);
            check("par_chk_en",  int'(par_chk_en),  e_par);
            check("stp_chk_en",  int'(stp_chk_en),  e_stp);
            check("data_valid",  int'(data_valid),  e_dv);
            check("frame_err",   int'(frame_err),   e_fe);

            if (deser_en)    deser_q.push_back(cyc);
            if (strt_chk_en) strt_q.push_back(cyc);
            if (par_chk_en)  par_q.push_back(cyc);
            if (stp_chk_en)  stp_q.push_back(cyc);
            if (data_valid)  dv_q.push_back(cyc);
            if (frame_err)   fe_q.push_back(cyc);
            if (dv_prev)     edge_after_dv_q.push_back(int'(edge_cnt));
            dv_prev <= data_valid;

            if (!m_active) begin
                if (!rx_in) begin
                    m_active <= 1'b1;
                    m_off    <= 0;
                    m_b2b    <= 1'b0;
                    m_p      <= eff_p(prescale);
                    m_pe     <= par_en;
                end
            end else if (m_off == m_p && strt_glitch) begin
                m_active <= 1'b0;
            end else if (m_off == len) begin
                m_flag <= 1'b0;
                if (!rx_in) begin
                    m_off <= 1;
                    m_b2b <= 1'b1;
                    m_p   <= eff_p(prescale);
                    m_pe  <= par_en;
                end else begin
                    m_active <= 1'b0;
                end
            end else begin
                m_off <= m_off + 1;
                if (m_pe && m_off == (DW + 1 + int'(m_pe)) * m_p) m_flag <= par_err;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            rx_in = 1'b1;
        end
    endtask

    task automatic clear_logs();
        deser_q.delete(); strt_q.delete(); par_q.delete(); stp_q.delete();
        dv_q.delete(); fe_q.delete(); edge_after_dv_q.delete();
    endtask

    // Drives start, LSB-first data, optional even parity and stop; t0 is the first START cycle
    task automatic drive_frame(input logic [7:0] d, input int p, input logic pe, output int t0);
        logic [10:0] bits;
        int          nb;
        bits = {1'b1, (pe ? ^d : 1'b1), d, 1'b0};
        nb   = pe ? 11 : 10;
        t0   = 0;
        for (int b = 0; b < nb; b++) begin
            for (int i = 0; i < p; i++) begin
                tick();
                if (b == 0 && i == 0) t0 = cyc + 1;
                rx_in = bits[b];
            end
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_samp"},  int'(dat_samp_en), 0);
        check({tag, "_edge"},  int'(edge_cnt),    0);
        check({tag, "_bit"},   int'(bit_cnt),     0);
        check({tag, "_deser"}, int'(deser_en),    0);
        check({tag, "_strt"},  int'(strt_chk_en), 0);
        check({tag, "_par"},   int'(par_chk_en),  0);
        check({tag, "_stp"},   int'(stp_chk_en),  0);
        check({tag, "_dv"},    int'(data_valid),  0);
        check({tag, "_fe"},    int'(frame_err),   0);
    endtask

    initial begin
        rst_n = 1'b0; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(10);

        // P=8, no parity, 0xA5, clean checkers
        clear_logs();
        drive_frame(8'hA5, 8, 1'b0, s);
        idle(6);
        check("t1_deser_count", deser_q.size(), 8);
        if (deser_q.size() == 8)
            for (int i = 0; i < 8; i++) check("t1_deser_time", deser_q[i] - s, 15 + 8 * i);
        check_evt("t1_strt", strt_q.size(), 1, (strt_q.size() > 0) ? strt_q[0] - s : -1, 7);
        check_evt("t1_stp",  stp_q.size(),  1, (stp_q.size()  > 0) ? stp_q[0]  - s : -1, 79);
        check_evt("t1_dv",   dv_q.size(),   1, (dv_q.size()   > 0) ? dv_q[0]   - s : -1, 80);
        check("t1_fe_count", fe_q.size(), 0);
        check("t1_idle_samp", int'(dat_samp_en), 0);

        // P=16 with parity, parity checker reports an error
        idle(5);
        clear_logs();
        prescale = 6'd16; par_en = 1'b1; par_err = 1'b1;
        drive_frame(8'h3C, 16, 1'b1, s);
        idle(6);
        check_evt("t2_par", par_q.size(), 1, (par_q.size() > 0) ? par_q[0] - s : -1, 159);
        check_evt("t2_fe",  fe_q.size(),  1, (fe_q.size()  > 0) ? fe_q[0]  - s : -1, 176);
        check("t2_dv_count", dv_q.size(), 0);
        par_err = 1'b0; par_en = 1'b0; prescale = 6'd8;

        // P=8, start checker flags a glitch
        idle(5);
        clear_logs();
        strt_glitch = 1'b1;
        drive_frame(8'hFF, 8, 1'b0, s);
        idle(6);
        check("t3_strt_count",  strt_q.size(),  1);
        check("t3_deser_count", deser_q.size(), 0);
        check("t3_stp_count",   stp_q.size(),   0);
        check("t3_dv_count",    dv_q.size(),    0);
        check("t3_fe_count",    fe_q.size(),    0);
        strt_glitch = 1'b0;

        // Back-to-back frames, line low in the verdict cycle
        idle(5);
        clear_logs();
        drive_frame(8'h5A, 8, 1'b0, s1);
        tick();
        rx_in = 1'b1;
        drive_frame(8'hC3, 8, 1'b0, s2);
        idle(6);
        check("t4_dv_count", dv_q.size(), 2);
        if (dv_q.size() == 2) begin
            check("t4_dv_first", dv_q[0] - s1, 80);
            check("t4_dv_gap",   dv_q[1] - dv_q[0], 80);
        end
        check("t4_edge_after_done", (edge_after_dv_q.size() > 0) ? edge_after_dv_q[0] : -1, 1);
        check("t4_fe_count", fe_q.size(), 0);

        // Ratio below minimum, then a mid-frame ratio change that must not take effect
        idle(5);
        clear_logs();
        prescale = 6'd4;
        fork
            drive_frame(8'h96, 8, 1'b0, s);
            begin
                repeat (20) tick();
                prescale = 6'd32;
            end
        join
        idle(6);
        check_evt("t5_dv", dv_q.size(), 1, (dv_q.size() > 0) ? dv_q[0] - s : -1, 80);
        idle(4);
        clear_logs();
        drive_frame(8'h96, 32, 1'b0, s);
        idle(6);
        check_evt("t5_dv32", dv_q.size(), 1, (dv_q.size() > 0) ? dv_q[0] - s : -1, 320);
        prescale = 6'd8;

        // Asynchronous reset in the middle of data bit 3
        idle(5);
        clear_logs();
        tick();
        rx_in = 1'b0;
        s = cyc + 1;
        for (int i = 0; i < 36; i++) begin
            tick();
            rx_in = (i < 6) ? 1'b0 : 1'b1;
        end
        check("t6_bit_before_rst",  int'(bit_cnt),  3);
        check("t6_edge_before_rst", int'(edge_cnt), 3);
        #2 rst_n = 1'b0;
        #1;
        check_outputs_zero("t6_in_reset");
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(100);
        check("t6_dv_after_rst", dv_q.size(), 0);
        check("t6_fe_after_rst", fe_q.size(), 0);
        clear_logs();
        drive_frame(8'h81, 8, 1'b0, s);
        idle(6);
        check_evt("t6_dv_fresh", dv_q.size(), 1, (dv_q.size() > 0) ? dv_q[0] - s : -1, 80);

        // Randomized line, checker results and ratio against the frame model
        for (int i = 0; i < 15000; i++) begin
            tick();
            rx_in       = ($urandom_range(0, 3) != 0);
            strt_glitch = ($urandom_range(0, 7) == 0);
            par_err     = ($urandom_range(0, 2) == 0);
            stp_err     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) prescale = 6'(ptab[$urandom_range(0, 5)]);
            if (!m_active && $urandom_range(0, 7) == 0) par_en = ($urandom_range(0, 1) == 1);
        end
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        idle(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
